// File: rtl/digital_lock_pkg.sv
// Shared definitions for the digital lock controller: FSM state encoding,
// special key codes and the digit-key classifier.
package digital_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    LOCKOUT,
    UNLOCKED,
    NEW,
    CONFIRM,
    COMMIT
  } state_t;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_LOCK   = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_access_controller_if.sv
// Keypad input and status output bundle of the lock access controller.
interface lock_access_controller_if #(
  parameter int DIGITS    = 4,
  parameter int MAX_FAILS = 3
);
  localparam int CODE_LENGTH   = 4 * DIGITS;
  localparam int COUNTER_WIDTH = $clog2(DIGITS);
  localparam int FAIL_WIDTH    = $clog2(MAX_FAILS + 1);

  logic                   key_valid;
  logic [3:0]             key_value;
  logic                   locked;
  logic [CODE_LENGTH-1:0] pin_entry;
  logic [COUNTER_WIDTH:0] digit_count;
  logic                   lockout;
  logic [FAIL_WIDTH-1:0]  fail_count;
  logic                   unlock_pulse;
  logic                   code_changed;
  logic                   error_pulse;

  modport master (
    output key_valid, key_value,
    input  locked, pin_entry, digit_count, lockout, fail_count,
           unlock_pulse, code_changed, error_pulse
  );

  modport slave (
    input  key_valid, key_value,
    output locked, pin_entry, digit_count, lockout, fail_count,
           unlock_pulse, code_changed, error_pulse
  );

endinterface

// File: rtl/lock_lockout_timer.sv
// Loadable down-counter that times the failed-attempt lockout window.
module lock_lockout_timer #(
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int WIDTH = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             active,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // expire marks the last cycle of the window, i.e. when count has reached zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) begin
        active <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign expire = active && (count == '0);

endmodule

// File: rtl/lock_access_controller.sv
// Digital lock sequencer: collects PIN digits, checks them against the stored
// code, enforces the failed-attempt lockout and handles code changes.
module lock_access_controller
  import digital_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CODE_LENGTH    = 4 * DIGITS,
  parameter int COUNTER_WIDTH  = $clog2(DIGITS),
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter logic [CODE_LENGTH-1:0] DEFAULT_CODE = 16'h1234
) (
  input logic clock,
  input logic reset,
  lock_access_controller_if.slave bus
);

  localparam int FAIL_WIDTH  = $clog2(MAX_FAILS + 1);
  localparam int TIMER_WIDTH = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0]  TIMER_LOAD = TIMER_WIDTH'(LOCKOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH:0]  LAST_DIGIT = (COUNTER_WIDTH + 1)'(DIGITS - 1);
  localparam logic [FAIL_WIDTH-1:0]   FAIL_LIMIT = FAIL_WIDTH'(MAX_FAILS);
  localparam logic [FAIL_WIDTH-1:0]   LAST_FAIL  = FAIL_WIDTH'(MAX_FAILS - 1);

  state_t                 state, state_nxt;
  logic [CODE_LENGTH-1:0] entry, entry_nxt, code_reg, code_nxt, hold_reg, hold_nxt;
  logic [COUNTER_WIDTH:0] count, count_nxt;
  logic [FAIL_WIDTH-1:0]  fails, fails_nxt;
  logic                   locked, locked_nxt, lockout, lockout_nxt;
  logic                   unlock_q, unlock_nxt, changed_q, changed_nxt, error_q, error_nxt;
  logic                   timer_load, timer_active, timer_expire;
  logic                   digit_key, clear_key, lock_key, change_key, last_digit;
  logic [CODE_LENGTH+3:0] shift_wide;
  logic [CODE_LENGTH-1:0] shifted;

  lock_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .WIDTH         (TIMER_WIDTH)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(TIMER_LOAD),
    .active    (timer_active),
    .expire    (timer_expire)
  );

  assign digit_key  = bus.key_valid && is_digit(bus.key_value);
  assign clear_key  = bus.key_valid && (bus.key_value == KEY_CLEAR);
  assign lock_key   = bus.key_valid && (bus.key_value == KEY_LOCK);
  assign change_key = bus.key_valid && (bus.key_value == KEY_CHANGE);
  assign last_digit = (count == LAST_DIGIT);
  assign shift_wide = {entry, bus.key_value};
  assign shifted    = shift_wide[CODE_LENGTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ENTRY;
      entry     <= '0;
      count     <= '0;
      fails     <= '0;
      code_reg  <= DEFAULT_CODE;
      hold_reg  <= '0;
      locked    <= 1'b1;
      lockout   <= 1'b0;
      unlock_q  <= 1'b0;
      changed_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      entry     <= entry_nxt;
      count     <= count_nxt;
      fails     <= fails_nxt;
      code_reg  <= code_nxt;
      hold_reg  <= hold_nxt;
      locked    <= locked_nxt;
      lockout   <= lockout_nxt;
      unlock_q  <= unlock_nxt;
      changed_q <= changed_nxt;
      error_q   <= error_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    entry_nxt   = entry;
    count_nxt   = count;
    fails_nxt   = fails;
    code_nxt    = code_reg;
    hold_nxt    = hold_reg;
    locked_nxt  = locked;
    lockout_nxt = lockout;
    unlock_nxt  = 1'b0;
    changed_nxt = 1'b0;
    error_nxt   = 1'b0;
    timer_load  = 1'b0;

    case (state)
      ENTRY: begin
        if (digit_key) begin
          entry_nxt = shifted;
          count_nxt = count + 1'b1;
          if (last_digit) state_nxt = CHECK;
        end else if (clear_key) begin
          entry_nxt = '0;
          count_nxt = '0;
        end
      end

      CHECK: begin
        entry_nxt = '0;
        count_nxt = '0;
        if (entry == code_reg) begin
          locked_nxt = 1'b0;
          unlock_nxt = 1'b1;
          fails_nxt  = '0;
          state_nxt  = UNLOCKED;
        end else begin
          error_nxt = 1'b1;
          if (fails == LAST_FAIL) begin
            fails_nxt   = FAIL_LIMIT;
            lockout_nxt = 1'b1;
            timer_load  = 1'b1;
            state_nxt   = LOCKOUT;
          end else begin
            fails_nxt = fails + 1'b1;
            state_nxt = ENTRY;
          end
        end
      end

      // An idle timer here would be a stuck lockout, so treat it as expired
      LOCKOUT: begin
        if (timer_expire || !timer_active) begin
          lockout_nxt = 1'b0;
          fails_nxt   = '0;
          state_nxt   = ENTRY;
        end
      end

      UNLOCKED: begin
        if (lock_key) begin
          locked_nxt = 1'b1;
          state_nxt  = ENTRY;
        end else if (change_key) begin
          state_nxt = NEW;
        end
      end

      NEW: begin
        if (digit_key) begin
          if (last_digit) begin
            hold_nxt  = shifted;
            entry_nxt = '0;
            count_nxt = '0;
            state_nxt = CONFIRM;
          end else begin
            entry_nxt = shifted;
            count_nxt = count + 1'b1;
          end
        end else if (clear_key) begin
          entry_nxt = '0;
          count_nxt = '0;
          state_nxt = UNLOCKED;
        end
      end

      CONFIRM: begin
        if (digit_key) begin
          entry_nxt = shifted;
          count_nxt = count + 1'b1;
          if (last_digit) state_nxt = COMMIT;
        end else if (clear_key) begin
          entry_nxt = '0;
          count_nxt = '0;
          state_nxt = UNLOCKED;
        end
      end

      COMMIT: begin
        if (entry == hold_reg) begin
          code_nxt    = hold_reg;
          changed_nxt = 1'b1;
        end else begin
          error_nxt = 1'b1;
        end
        entry_nxt = '0;
        count_nxt = '0;
        hold_nxt  = '0;
        state_nxt = UNLOCKED;
      end

      default: state_nxt = ENTRY;
    endcase
  end

  assign bus.locked       = locked;
  assign bus.pin_entry    = entry;
  assign bus.digit_count  = count;
  assign bus.lockout      = lockout;
  assign bus.fail_count   = fails;
  assign bus.unlock_pulse = unlock_q;
  assign bus.code_changed = changed_q;
  assign bus.error_pulse  = error_q;

endmodule

// File: doc/lock_access_controller.md
Name: lock_access_controller

Overview:
- Sequencing controller for the digital lock datapath: accepts debounced keypad events and collects PIN digits into an entry register.
- Compares the entry against a stored code register and drives the locked/unlocked state.
- Enforces a failed-attempt lockout and sequences an authorised code-change (enter + confirm) that reconfigures the stored code.

Parameters:
DIGITS, 4, digits per PIN
CODE_LENGTH, 4*DIGITS, bits of stored code / entry
COUNTER_WIDTH, $clog2(DIGITS), digit counter width minus one
MAX_FAILS, 3, consecutive wrong codes before lockout (>=1)
LOCKOUT_CYCLES, 50_000_000, lockout duration in clock cycles (>=1)
DEFAULT_CODE, 16'h1234, code loaded at reset (BCD, CODE_LENGTH bits)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
key_valid  in  1  one-cycle pulse per key press
key_value  in  4  0-9 digit; 4'hA CLEAR; 4'hB LOCK; 4'hC CHANGE; others ignored
locked  out  1  1 = locked
pin_entry  out  CODE_LENGTH  digits entered so far, newest in [3:0]
digit_count  out  COUNTER_WIDTH+1  digits entered so far
lockout  out  1  1 while in lockout
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures
unlock_pulse  out  1  one cycle on successful unlock
code_changed  out  1  one cycle on committed code change
error_pulse  out  1  one cycle on wrong code or confirm mismatch

Behaviour:
- One clock; reset is synchronous and active-high, port names clock and reset. Reset dominates every other input, including mid-lockout and mid-entry.
- Reset values:
  - locked=1, lockout=0, all pulses 0
  - pin_entry=0, digit_count=0, fail_count=0
  - code_reg=DEFAULT_CODE, hold_reg=0, timer=0
  - state=ENTRY
- Digit accept, on a key_valid cycle with a digit key in ENTRY/NEW/CONFIRM:
  - pin_entry <= {pin_entry[CODE_LENGTH-5:0], key_value}; digit_count++.
  - Outputs are registered and visible the next cycle.
- States and transitions:
  - ENTRY (locked):
    - digit: accept; the DIGITS-th accept moves to CHECK.
    - CLEAR: pin_entry=0, count=0.
    - LOCK/CHANGE/other: ignored.
  - CHECK (1 cycle, all keys dropped):
    - Match: locked<=0, unlock_pulse, fail_count<=0, entry cleared, go to UNLOCKED.
    - Mismatch: error_pulse, entry cleared. If fail_count+1==MAX_FAILS: fail_count<=MAX_FAILS, timer<=LOCKOUT_CYCLES-1, lockout<=1, go to LOCKOUT. Otherwise fail_count++ and go to ENTRY.
  - LOCKOUT:
    - All keys dropped; timer decrements each cycle.
    - On the cycle timer==0: lockout<=0, fail_count<=0, go to ENTRY. Total lockout = LOCKOUT_CYCLES cycles.
    - A key arriving on the expiry cycle is dropped.
  - UNLOCKED:
    - LOCK: locked<=1, go to ENTRY.
    - CHANGE: go to NEW.
    - Digits/CLEAR/other: ignored.
  - NEW:
    - Digit: accept; on the DIGITS-th digit, hold_reg<=new entry value, entry cleared, go to CONFIRM.
    - CLEAR: abort, entry cleared, go to UNLOCKED.
  - CONFIRM:
    - Digit: accept; on the DIGITS-th digit go to COMMIT.
    - CLEAR: abort as in NEW.
  - COMMIT (1 cycle, keys dropped):
    - entry==hold_reg: code_reg<=hold_reg, code_changed.
    - Otherwise: error_pulse, code_reg unchanged.
    - Both cases: entry and hold cleared, go to UNLOCKED.
- Widths:
  - digit_count never exceeds DIGITS and resets to 0 on leaving any entry state.
  - fail_count saturates at MAX_FAILS.
  - Digit keys are values 0-9 only; A-F are never shifted in.
- Pulses are exactly one cycle and mutually exclusive.
- locked=0 only in UNLOCKED/NEW/CONFIRM/COMMIT.

Decomposition:
- Shared package (digital_lock_pkg) holds:
  - state encoding constants: ENTRY, CHECK, LOCKOUT, UNLOCKED, NEW, CONFIRM, COMMIT
  - key codes: KEY_CLEAR=4'hA, KEY_LOCK=4'hB, KEY_CHANGE=4'hC
- One sub-module: lock_lockout_timer.
  - Ports: load, load_value; outputs active and expire.
  - Down-counter sized $clog2(LOCKOUT_CYCLES).
- Digit shift/compare and the FSM stay in the top module.

Test Plan:
- Reset, then keys 1,2,3,4 -> CHECK cycle after the 4th, then unlock_pulse=1 for one cycle, locked=0, fail_count=0, digit_count=0.
- Locked; keys 1,2, CLEAR, 1,2,3,4 -> pin_entry=0 after CLEAR, then unlock as above. Keys LOCK/CHANGE while locked -> no state change.
- Three wrong codes (9,9,9,9 x3; LOCKOUT_CYCLES=10) -> error_pulse x3, fail_count 1,2,3, lockout=1 for exactly 10 cycles. Keys during lockout are ignored; afterwards fail_count=0 and 1,2,3,4 unlocks.
- Unlocked; CHANGE, 5,6,7,8, 5,6,7,8 -> code_changed pulse. LOCK, then 1,2,3,4 -> error_pulse; 5,6,7,8 -> unlock.
- Unlocked; CHANGE, 5,6,7,8, 5,6,7,9 -> error_pulse, code stays 1234. CHANGE, 1, CLEAR -> back to UNLOCKED with entry cleared.
- Assert reset mid-lockout and mid-NEW entry -> all outputs return to reset values next cycle; code_reg back to 16'h1234.
